attn_out_residual_add: RTL
==========================

ATTN_OUT_RESIDUAL_ADD -- requirements
Module: attn_out_residual_add

Interface
REQ-001 Parameters: READ_LAT, default 2, residual SRAM read latency; MEM_WAIT, default READ_LAT+1, wait cycles after address update; NUM_BEATS, default 128, beats per tile (4 rows x 32 groups).
REQ-002 Reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 start  in  1  begins one tile; only a rising edge counts.
REQ-006 in_valid  in  1  beat present from the GEMM stream; no backpressure toward the producer.
REQ-007 in_row  in  2  row index of the beat.
REQ-008 in_group  in  5  group index of the beat.
REQ-009 in_data  in  128  four FP32 lanes; lane n is bits [32n+31:32n].
REQ-010 R_mem_addr  out  7  residual SRAM read address.
REQ-011 R_mem_out  in  128  residual SRAM read data.
REQ-012 W_mem_we  out  1  one-cycle write strobe.
REQ-013 W_mem_addr  out  7  result write address.
REQ-014 W_mem_din  out  128  result word, same lane order as in_data.
REQ-015 busy  out  1  high from accepted start to done.
REQ-016 done  out  1  one-cycle pulse after the last write.
REQ-017 overflow  out  1  sticky flag: a beat was dropped.

Function
REQ-018 Input FIFO: 2 entries of {row, group, data}; it SHALL push whenever in_valid=1 and it is not full, in any FSM state.
REQ-019 in_valid=1 with the FIFO full and no pop in the same cycle SHALL drop the beat and set overflow; a push and pop in the same cycle while full SHALL accept the beat.
REQ-020 FSM states: S_IDLE, S_POP, S_SET_ADDR, S_WAIT_MEM, S_LATCH_MEM, S_ADD_SEND, S_ADD_WAIT, S_NEXT_LANE, S_WRITE, S_DONE.
REQ-021 S_IDLE: busy=0; on a start edge, busy<=1, beat count<=0, overflow<=0, flush FIFO, go to S_POP; a start edge while busy SHALL be ignored.
REQ-022 S_POP: wait while the FIFO is empty; otherwise pop and latch the beat into a working register.
REQ-023 S_SET_ADDR: R_mem_addr <= {row, group} (row*32 + group), clear the wait counter.
REQ-024 S_WAIT_MEM: count to MEM_WAIT, then move to S_LATCH_MEM, which latches R_mem_out and sets lane to 0.
REQ-025 Addition: lanes 0..3 are added serially through one FP32 adder.
REQ-026 S_ADD_SEND: drive a = beat lane and b = residual lane, and raise both strobes.
REQ-027 S_ADD_WAIT: drop each strobe on its own ack; on output_z_stb, store the sum in result lane.
REQ-028 S_NEXT_LANE: go to S_WRITE at lane 3, else increment lane and return to S_ADD_SEND.
REQ-029 S_WRITE: pulse W_mem_we=1 for one cycle with W_mem_addr={row,group} and W_mem_din={r3,r2,r1,r0}; increment beat count.
REQ-030 After S_WRITE: go to S_DONE if beat count equals NUM_BEATS, else S_POP.
REQ-031 S_DONE: done=1 and busy<=0 for one cycle, then S_IDLE.
REQ-032 Address comes from the beat, not a counter: out-of-order and repeated beats SHALL write to their own addresses; duplicates still count.
REQ-033 The adder result is taken as produced, with no rounding change; NaN, Inf and signed zeros pass through as the adder emits them.
REQ-034 Beats arriving in S_IDLE SHALL be held in the FIFO, then flushed by the next start.

Reset
REQ-035 On rst, all outputs SHALL go to 0: R_mem_addr, W_mem_we, W_mem_addr, W_mem_din, busy, done, overflow.
REQ-036 On rst, internal state SHALL clear: FSM to S_IDLE, FIFO empty, counters, lane and result registers zero, adder strobes low.
REQ-037 Reset mid-operation SHALL abort the tile with no further write; the adder SHALL be reset by the same rst.

Structure
REQ-038 Shared package attn_out_pkg: state enum, READ_LAT, NUM_ROWS=4, NUM_GROUPS=32, LANE_W=32, and the address packing {row, group}.
REQ-039 Exactly one sub-module: adder (FP32 handshake adder) with output_z_ack tied to 1.
REQ-040 The FIFO SHALL be inline logic, not a separate module.

Verification
REQ-041 One beat, row=1, group=5, all lanes 3F800000, residual at addr 37 all 40000000 -> one write, addr 37, data 4x40400000.
REQ-042 128 beats in order, residual = 0 -> 128 writes with din equal to in_data, then exactly one done pulse, busy=0 after it.
REQ-043 Three back-to-back in_valid beats while the FSM is in S_ADD_WAIT -> beats 1 and 2 kept, beat 3 dropped, overflow=1 until the next start.
REQ-044 rst asserted during S_ADD_WAIT of lane 2 -> no write occurs, all outputs 0 on the next cycle; a following start and full tile complete normally.
REQ-045 Beat lanes {BF800000, 3F800000, 7F800000, 00000000} plus residual {3F800000, 3F800000, 3F800000, 80000000} -> {00000000, 40000000, 7F800000, 00000000}.
REQ-046 A start pulse mid-tile is ignored (count unaffected), and a start held high for 5 cycles starts only one tile.

Source files
------------

// File: rtl/attn_out_pkg.sv
// Shared types and constants for the attention-output residual add stage.
// A beat address packs the row above the group: addr = row*32 + group.
package attn_out_pkg;

  localparam int READ_LAT   = 2;
  localparam int NUM_ROWS   = 4;
  localparam int NUM_GROUPS = 32;
  localparam int LANE_W     = 32;
  localparam int NUM_LANES  = 4;
  localparam int ROW_W      = 2;
  localparam int GROUP_W    = 5;
  localparam int ADDR_W     = ROW_W + GROUP_W;
  localparam int WORD_W     = NUM_LANES * LANE_W;

  typedef enum logic [3:0] {
    S_IDLE,
    S_POP,
    S_SET_ADDR,
    S_WAIT_MEM,
    S_LATCH_MEM,
    S_ADD_SEND,
    S_ADD_WAIT,
    S_NEXT_LANE,
    S_WRITE,
    S_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [ROW_W-1:0] row,
                                                   input logic [GROUP_W-1:0] group);
    return {row, group};
  endfunction

endpackage

// File: rtl/attn_out_residual_add_adder.sv
// FP32 adder with strobe/ack handshakes on both operands and the result.
// Round-to-nearest-even; subnormal operands and results are flushed to signed zero.
module adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  input  logic [31:0] input_b,
  input  logic        input_b_stb,
  output logic        input_b_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  localparam logic [1:0] A_GET_A = 2'd0;
  localparam logic [1:0] A_GET_B = 2'd1;
  localparam logic [1:0] A_ADD   = 2'd2;
  localparam logic [1:0] A_PUT   = 2'd3;

  logic [1:0]        st_reg;
  logic [31:0]       a_reg, b_reg;
  logic [31:0]       x, y, z_next;
  logic [7:0]        d;
  logic [26:0]       mx, my_al, n;
  logic [53:0]       sh;
  logic [27:0]       s;
  logic [4:0]        lz;
  logic [24:0]       r;
  logic              up;
  logic signed [9:0] e_n, e_r;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  assign a_nan  = (&a_reg[30:23]) && (|a_reg[22:0]);
  assign b_nan  = (&b_reg[30:23]) && (|b_reg[22:0]);
  assign a_inf  = (&a_reg[30:23]) && !(|a_reg[22:0]);
  assign b_inf  = (&b_reg[30:23]) && !(|b_reg[22:0]);
  assign a_zero = (a_reg[30:23] == 8'd0);
  assign b_zero = (b_reg[30:23] == 8'd0);

  always_comb begin
    // x carries the larger magnitude so the aligned difference is never negative
    x     = (b_reg[30:0] > a_reg[30:0]) ? b_reg : a_reg;
    y     = (b_reg[30:0] > a_reg[30:0]) ? a_reg : b_reg;
    d     = x[30:23] - y[30:23];
    mx    = {1'b1, x[22:0], 3'b000};
    sh    = {{1'b1, y[22:0], 3'b000}, 27'd0} >> ((d > 8'd31) ? 8'd31 : d);
    my_al = {sh[53:28], sh[27] | (|sh[26:0])};
    s     = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, my_al}) : ({1'b0, mx} - {1'b0, my_al});
    lz    = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (s[i]) lz = 5'(26 - i);
    end
    e_n = $signed({2'b00, x[30:23]});
    if (s[27]) begin
      n   = {s[27:2], s[1] | s[0]};
      e_n = e_n + 10'sd1;
    end else begin
      n   = s[26:0] << lz;
      e_n = e_n - $signed({5'd0, lz});
    end
    up  = n[2] & (n[1] | n[0] | n[3]);
    r   = {1'b0, n[26:3]} + {24'd0, up};
    e_r = e_n + $signed({9'd0, r[24]});
    if (s == 28'd0)            z_next = 32'd0;
    else if (e_r >= 10'sd255)  z_next = {x[31], 8'hFF, 23'd0};
    else if (e_r <= 10'sd0)    z_next = {x[31], 31'd0};
    else                       z_next = {x[31], e_r[7:0], r[24] ? r[23:1] : r[22:0]};
    if (a_nan || b_nan || (a_inf && b_inf && (a_reg[31] != b_reg[31]))) z_next = 32'h7FC00000;
    else if (a_inf)                 z_next = a_reg;
    else if (b_inf)                 z_next = b_reg;
    else if (a_zero && b_zero)      z_next = {a_reg[31] & b_reg[31], 31'd0};
    else if (a_zero)                z_next = b_reg;
    else if (b_zero)                z_next = a_reg;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st_reg       <= A_GET_A;
      a_reg        <= '0;
      b_reg        <= '0;
      input_a_ack  <= 1'b0;
      input_b_ack  <= 1'b0;
      output_z     <= '0;
      output_z_stb <= 1'b0;
    end else begin
      case (st_reg)
        A_GET_A: begin
          input_a_ack <= 1'b1;
          if (input_a_ack && input_a_stb) begin
            a_reg       <= input_a;
            input_a_ack <= 1'b0;
            st_reg      <= A_GET_B;
          end
        end
        A_GET_B: begin
          input_b_ack <= 1'b1;
          if (input_b_ack && input_b_stb) begin
            b_reg       <= input_b;
            input_b_ack <= 1'b0;
            st_reg      <= A_ADD;
          end
        end
        A_ADD: begin
          output_z     <= z_next;
          output_z_stb <= 1'b1;
          st_reg       <= A_PUT;
        end
        default: begin
          if (output_z_stb && output_z_ack) begin
            output_z_stb <= 1'b0;
            st_reg       <= A_GET_A;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/attn_out_residual_add.sv
// Residual add for attention-output tiles: each GEMM beat is added lane by lane to the
// residual word at its own {row, group} address and the sum is written back there.
module attn_out_residual_add
  import attn_out_pkg::*;
#(
  parameter int READ_LAT  = attn_out_pkg::READ_LAT,
  parameter int MEM_WAIT  = READ_LAT + 1,
  parameter int NUM_BEATS = NUM_ROWS * NUM_GROUPS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         in_valid,
  input  logic [1:0]   in_row,
  input  logic [4:0]   in_group,
  input  logic [127:0] in_data,
  output logic [6:0]   R_mem_addr,
  input  logic [127:0] R_mem_out,
  output logic         W_mem_we,
  output logic [6:0]   W_mem_addr,
  output logic [127:0] W_mem_din,
  output logic         busy,
  output logic         done,
  output logic         overflow
);

  localparam int ENTRY_W = ROW_W + GROUP_W + WORD_W;
  localparam int CNT_W   = $clog2(NUM_BEATS + 1);

  state_t              state_reg;
  logic                start_d_reg;
  logic [ENTRY_W-1:0]  fifo_mem [2];
  logic                wr_ptr_reg, rd_ptr_reg;
  logic [1:0]          fifo_cnt_reg;
  logic [ROW_W-1:0]    row_reg;
  logic [GROUP_W-1:0]  group_reg;
  logic [WORD_W-1:0]   data_reg, res_reg, din_next;
  logic [LANE_W-1:0]   result_reg [NUM_LANES];
  logic [LANE_W-1:0]   beat_lane [NUM_LANES];
  logic [LANE_W-1:0]   res_lane [NUM_LANES];
  logic [1:0]          lane_reg;
  logic [7:0]          wait_cnt_reg;
  logic [CNT_W-1:0]    beat_cnt_reg;
  logic                a_stb_reg, b_stb_reg;
  logic                a_ack, b_ack, z_stb;
  logic [LANE_W-1:0]   z;
  logic                start_edge, flush, fifo_full, fifo_empty, push, pop;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign beat_lane[gi]                    = data_reg[LANE_W*gi +: LANE_W];
      assign res_lane[gi]                     = res_reg[LANE_W*gi +: LANE_W];
      assign din_next[LANE_W*gi +: LANE_W]    = result_reg[gi];
    end
  endgenerate

  assign start_edge = start && !start_d_reg;
  assign flush      = (state_reg == S_IDLE) && start_edge;
  assign fifo_full  = (fifo_cnt_reg == 2'd2);
  assign fifo_empty = (fifo_cnt_reg == 2'd0);
  assign pop        = (state_reg == S_POP) && !fifo_empty;
  // A full FIFO still accepts a beat when the same cycle pops one out.
  assign push       = in_valid && (!fifo_full || pop) && !flush;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= {in_row, in_group, in_data};
  end

  adder u_adder (
    .clk          (clk),
    .rst          (rst),
    .input_a      (beat_lane[lane_reg]),
    .input_a_stb  (a_stb_reg),
    .input_a_ack  (a_ack),
    .input_b      (res_lane[lane_reg]),
    .input_b_stb  (b_stb_reg),
    .input_b_ack  (b_ack),
    .output_z     (z),
    .output_z_stb (z_stb),
    .output_z_ack (1'b1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      start_d_reg  <= 1'b0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      fifo_cnt_reg <= 2'd0;
      row_reg      <= '0;
      group_reg    <= '0;
      data_reg     <= '0;
      res_reg      <= '0;
      for (int i = 0; i < NUM_LANES; i++) result_reg[i] <= '0;
      lane_reg     <= 2'd0;
      wait_cnt_reg <= 8'd0;
      beat_cnt_reg <= '0;
      a_stb_reg    <= 1'b0;
      b_stb_reg    <= 1'b0;
      R_mem_addr   <= '0;
      W_mem_we     <= 1'b0;
      W_mem_addr   <= '0;
      W_mem_din    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      start_d_reg <= start;
      W_mem_we    <= 1'b0;
      if (flush) begin
        wr_ptr_reg   <= 1'b0;
        rd_ptr_reg   <= 1'b0;
        fifo_cnt_reg <= 2'd0;
      end else begin
        if (push) wr_ptr_reg <= !wr_ptr_reg;
        if (pop)  rd_ptr_reg <= !rd_ptr_reg;
        case ({push, pop})
          2'b10:   fifo_cnt_reg <= fifo_cnt_reg + 2'd1;
          2'b01:   fifo_cnt_reg <= fifo_cnt_reg - 2'd1;
          default: ;
        endcase
      end
      if (flush)                                 overflow <= 1'b0;
      else if (in_valid && fifo_full && !pop)    overflow <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (start_edge) begin
            busy         <= 1'b1;
            beat_cnt_reg <= '0;
            state_reg    <= S_POP;
          end
        end
        S_POP: begin
          if (!fifo_empty) begin
            {row_reg, group_reg, data_reg} <= fifo_mem[rd_ptr_reg];
            state_reg <= S_SET_ADDR;
          end
        end
        S_SET_ADDR: begin
          R_mem_addr   <= pack_addr(row_reg, group_reg);
          wait_cnt_reg <= 8'd0;
          state_reg    <= S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          wait_cnt_reg <= wait_cnt_reg + 8'd1;
          if (wait_cnt_reg == 8'(MEM_WAIT - 1)) state_reg <= S_LATCH_MEM;
        end
        S_LATCH_MEM: begin
          res_reg   <= R_mem_out;
          lane_reg  <= 2'd0;
          state_reg <= S_ADD_SEND;
        end
        S_ADD_SEND: begin
          a_stb_reg <= 1'b1;
          b_stb_reg <= 1'b1;
          state_reg <= S_ADD_WAIT;
        end
        S_ADD_WAIT: begin
          if (a_stb_reg && a_ack) a_stb_reg <= 1'b0;
          if (b_stb_reg && b_ack) b_stb_reg <= 1'b0;
          if (z_stb) begin
            result_reg[lane_reg] <= z;
            state_reg            <= S_NEXT_LANE;
          end
        end
        S_NEXT_LANE: begin
          // The strobe is raised here so W_mem_we is high exactly while in S_WRITE.
          if (lane_reg == 2'd3) begin
            W_mem_we   <= 1'b1;
            W_mem_addr <= pack_addr(row_reg, group_reg);
            W_mem_din  <= din_next;
            state_reg  <= S_WRITE;
          end else begin
            lane_reg  <= lane_reg + 2'd1;
            state_reg <= S_ADD_SEND;
          end
        end
        S_WRITE: begin
          beat_cnt_reg <= beat_cnt_reg + CNT_W'(1);
          if (beat_cnt_reg + CNT_W'(1) == CNT_W'(NUM_BEATS)) begin
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            state_reg <= S_POP;
          end
        end
        S_DONE: begin
          done      <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
